// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue handshake bundle: icache request/response, decoder delivery and redirects.
// The master modport is the fetch queue; the slave modport is its surrounding front end.
interface inst_fetch_queue_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  need_inst;
    logic [ADDR_WIDTH-1:0] PC;
    logic                  inst_ready_in;
    logic [31:0]           inst_in;
    logic                  dc_stall;
    logic                  dc_clear;
    logic [ADDR_WIDTH-1:0] dc_new_pc;
    logic                  inst_ready_out;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic [31:0]           inst_out;
    logic                  inst_pred_taken;
    logic                  rob_clear;
    logic [ADDR_WIDTH-1:0] rob_new_pc;

    modport master (
        output need_inst, PC, inst_ready_out, inst_addr, inst_out, inst_pred_taken,
        input  inst_ready_in, inst_in, dc_stall, dc_clear, dc_new_pc, rob_clear, rob_new_pc
    );

    modport slave (
        input  need_inst, PC, inst_ready_out, inst_addr, inst_out, inst_pred_taken,
        output inst_ready_in, inst_in, dc_stall, dc_clear, dc_new_pc, rob_clear, rob_new_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential instruction fetcher with a 2**DEPTH_LOG-entry queue towards the decoder.
// Define IFQ_STATIC_PREDICT_EN to enable static JAL / backward-branch prediction.
module inst_fetch_queue #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH_LOG  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic                clk_in,
    input logic                rst_in,
    input logic                rdy_in,
    inst_fetch_queue_if.master ifq
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int PTR_W = (DEPTH_LOG > 0) ? DEPTH_LOG : 1;
    localparam int CNT_W = DEPTH_LOG + 1;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  halt_q;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [31:0]           inst_mem [DEPTH];

    logic                  need_inst_c;
    logic                  do_enq;
    logic                  do_deq;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  is_branch;
    logic                  halt_set;
    logic [ADDR_WIDTH-1:0] next_pc;

`ifdef IFQ_STATIC_PREDICT_EN
    logic                  pred_mem [DEPTH];
    logic                  pred_c;
    logic signed [20:0]    j_imm_c;
    logic signed [12:0]    b_imm_c;

    assign j_imm_c = {ifq.inst_in[31], ifq.inst_in[19:12], ifq.inst_in[20], ifq.inst_in[30:21], 1'b0};
    assign b_imm_c = {ifq.inst_in[31], ifq.inst_in[7], ifq.inst_in[30:25], ifq.inst_in[11:8], 1'b0};
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        is_jal      = (ifq.inst_in[6:0] == OP_JAL);
        is_jalr     = (ifq.inst_in[6:0] == OP_JALR);
        is_branch   = (ifq.inst_in[6:0] == OP_BRANCH);
        need_inst_c = !halt_q && (count_q < CNT_W'(DEPTH));
        // An all-zero word is an icache bubble, never a real instruction.
        do_enq      = need_inst_c && ifq.inst_ready_in && (ifq.inst_in != 32'd0);
        do_deq      = (count_q != '0) && !ifq.dc_stall;
        next_pc     = pc_q + ADDR_WIDTH'(4);
        halt_set    = is_jal || is_jalr || is_branch;
`ifdef IFQ_STATIC_PREDICT_EN
        pred_c      = 1'b0;
        halt_set    = is_jalr;
        if (is_jal) begin
            pred_c  = 1'b1;
            next_pc = pc_q + ADDR_WIDTH'(j_imm_c);
        end else if (is_branch && b_imm_c[12]) begin
            pred_c  = 1'b1;
            next_pc = pc_q + ADDR_WIDTH'(b_imm_c);
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else if (rdy_in) begin
            if (ifq.rob_clear || ifq.dc_clear) begin
                // The ROB flush is older than any decoder redirect, so its target wins.
                pc_q    <= ifq.rob_clear ? ifq.rob_new_pc : ifq.dc_new_pc;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                halt_q  <= 1'b0;
            end else begin
                if (do_enq) begin
                    tail_q <= ptr_inc(tail_q);
                    pc_q   <= next_pc;
                    if (halt_set) begin
                        halt_q <= 1'b1;
                    end
                end
                if (do_deq) begin
                    head_q <= ptr_inc(head_q);
                end
                if (do_enq && !do_deq) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!do_enq && do_deq) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

    // Queue storage carries no reset; the head outputs are masked while empty.
    always_ff @(posedge clk_in) begin
        if (rdy_in && do_enq && !ifq.rob_clear && !ifq.dc_clear) begin
            addr_mem[tail_q] <= pc_q;
            inst_mem[tail_q] <= ifq.inst_in;
`ifdef IFQ_STATIC_PREDICT_EN
            pred_mem[tail_q] <= pred_c;
`endif
        end
    end

    assign ifq.need_inst      = need_inst_c;
    assign ifq.PC             = pc_q;
    assign ifq.inst_ready_out = (count_q != '0);
    assign ifq.inst_addr      = ifq.inst_ready_out ? addr_mem[head_q] : '0;
    assign ifq.inst_out       = ifq.inst_ready_out ? inst_mem[head_q] : 32'd0;
`ifdef IFQ_STATIC_PREDICT_EN
    assign ifq.inst_pred_taken = ifq.inst_ready_out ? pred_mem[head_q] : 1'b0;
`else
    assign ifq.inst_pred_taken = 1'b0;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: decode table plus scoreboarded stream sequences.
module tb_inst_fetch_queue;
    localparam int          AW      = 32;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] ADDI    = 32'h00100093;
    localparam logic [31:0] BEQ_P8  = 32'h00000463;
    localparam logic [31:0] BNE_P16 = 32'h00001863;
    localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;
    localparam logic [31:0] JAL_M8  = 32'hFF9FF06F;
    localparam logic [31:0] JALR    = 32'h00008067;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        pred;
    } sb_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        need;
        logic [31:0] npc;
        logic        valid;
        logic        pred;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetch_queue_if #(.ADDR_WIDTH(AW)) ifc ();

    inst_fetch_queue #(
        .ADDR_WIDTH(AW),
        .DEPTH_LOG (2),
        .RESET_PC  (32'h0)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .ifq   (ifc)
    );

    always #5 clk_in = ~clk_in;

    sb_t         sb[$];
    logic [31:0] dlv[$];
    logic        dlv_pred[$];
    int          dlv_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic [31:0] m_pc;
    logic        m_halt;
    logic        icache_en;
    logic [31:0] fetch_limit;
    logic [31:0] sp_addr;
    logic [31:0] sp_inst;
    logic        redir_en;
    logic        redir_fired;
    logic [31:0] redir_addr;
    logic [31:0] redir_tgt;
    vec_t        vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_dlv(input string name, input int idx, input logic [31:0] exp);
        if (idx < dlv.size()) begin
            check(name, dlv[idx], exp);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: only %0d deliveries, expected addr 0x%08h at index %0d", name, dlv.size(), exp, idx);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a == sp_addr) ? sp_inst : ADDI;
    endfunction

    // Reference fetch decision: next fetch address, prediction and halt for one accepted word.
    task automatic model_fetch(input logic [31:0] pc, input logic [31:0] w,
                               output logic [31:0] nxt, output logic pred, output logic halt);
        logic [6:0] op;
`ifdef IFQ_STATIC_PREDICT_EN
        int jimm;
        int bimm;
        jimm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        bimm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
`endif
        op   = w[6:0];
        nxt  = pc + 32'd4;
        pred = 1'b0;
        halt = 1'b0;
`ifdef IFQ_STATIC_PREDICT_EN
        if (op == 7'h6F) begin
            pred = 1'b1;
            nxt  = pc + jimm;
        end else if (op == 7'h63 && bimm < 0) begin
            pred = 1'b1;
            nxt  = pc + bimm;
        end else if (op == 7'h67) begin
            halt = 1'b1;
        end
`else
        halt = (op == 7'h6F) || (op == 7'h67) || (op == 7'h63);
`endif
    endtask

    // One clock: icache/decoder stimulus, compare DUT against scoreboard, advance model.
    task automatic step();
        logic [31:0] nxt;
        logic        pred;
        logic        halt;
        logic        exp_need;
        sb_t         e;
        if (redir_fired) begin
            ifc.dc_clear = 1'b0;
            redir_fired  = 1'b0;
        end
        ifc.inst_ready_in = icache_en && (ifc.PC < fetch_limit);
        ifc.inst_in       = ifc.inst_ready_in ? word_at(ifc.PC) : 32'd0;
        if (redir_en && ifc.inst_ready_out && !ifc.dc_stall && ifc.inst_addr == redir_addr) begin
            ifc.dc_clear  = 1'b1;
            ifc.dc_new_pc = redir_tgt;
            redir_en      = 1'b0;
            redir_fired   = 1'b1;
        end
        exp_need = !m_halt && (sb.size() < DEPTH);
        check("need_inst", ifc.need_inst, exp_need);
        check("PC", ifc.PC, m_pc);
        check("inst_ready_out", ifc.inst_ready_out, sb.size() != 0);
        if (sb.size() != 0) begin
            check("head inst_addr", ifc.inst_addr, sb[0].addr);
            check("head inst_out", ifc.inst_out, sb[0].inst);
            check("head pred_taken", ifc.inst_pred_taken, sb[0].pred);
        end
        if (rdy_in && sb.size() != 0 && !ifc.dc_stall) begin
            dlv.push_back(sb[0].addr);
            dlv_pred.push_back(sb[0].pred);
            dlv_cyc.push_back(cyc);
            sb.delete(0);
        end
        if (rdy_in) begin
            if (ifc.rob_clear || ifc.dc_clear) begin
                sb.delete();
                m_halt = 1'b0;
                m_pc   = ifc.rob_clear ? ifc.rob_new_pc : ifc.dc_new_pc;
            end else if (exp_need && ifc.inst_ready_in && ifc.inst_in != 32'd0) begin
                model_fetch(m_pc, ifc.inst_in, nxt, pred, halt);
                e.addr = m_pc;
                e.inst = ifc.inst_in;
                e.pred = pred;
                sb.push_back(e);
                m_pc = nxt;
                if (halt) m_halt = 1'b1;
            end
        end
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_in            = 1'b1;
        rdy_in            = 1'b0;
        ifc.inst_ready_in = 1'b0;
        ifc.inst_in       = 32'd0;
        ifc.dc_stall      = 1'b0;
        ifc.dc_clear      = 1'b0;
        ifc.dc_new_pc     = 32'd0;
        ifc.rob_clear     = 1'b0;
        ifc.rob_new_pc    = 32'd0;
        icache_en         = 1'b0;
        redir_en          = 1'b0;
        redir_fired       = 1'b0;
        redir_addr        = 32'd0;
        redir_tgt         = 32'd0;
        fetch_limit       = 32'h1000;
        sp_addr           = 32'hFFFF_FFFC;
        sp_inst           = ADDI;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        sb.delete();
        dlv.delete();
        dlv_pred.delete();
        dlv_cyc.delete();
        m_pc   = 32'd0;
        m_halt = 1'b0;
        cyc    = 0;
    endtask

    initial begin
`ifdef IFQ_STATIC_PREDICT_EN
        vt[0] = '{32'h100, ADDI,    1'b1, 32'h104, 1'b1, 1'b0};
        vt[1] = '{32'h008, BEQ_P8,  1'b1, 32'h00C, 1'b1, 1'b0};
        vt[2] = '{32'h020, JAL_M8,  1'b1, 32'h018, 1'b1, 1'b1};
        vt[3] = '{32'h030, JALR,    1'b0, 32'h034, 1'b1, 1'b0};
        vt[4] = '{32'h030, BNE_P16, 1'b1, 32'h034, 1'b1, 1'b0};
        vt[5] = '{32'h040, BEQ_M4,  1'b1, 32'h03C, 1'b1, 1'b1};
        vt[6] = '{32'h050, 32'h0,   1'b1, 32'h050, 1'b0, 1'b0};
`else
        vt[0] = '{32'h100, ADDI,    1'b1, 32'h104, 1'b1, 1'b0};
        vt[1] = '{32'h008, BEQ_P8,  1'b0, 32'h00C, 1'b1, 1'b0};
        vt[2] = '{32'h020, JAL_M8,  1'b0, 32'h024, 1'b1, 1'b0};
        vt[3] = '{32'h030, JALR,    1'b0, 32'h034, 1'b1, 1'b0};
        vt[4] = '{32'h030, BNE_P16, 1'b0, 32'h034, 1'b1, 1'b0};
        vt[5] = '{32'h040, BEQ_M4,  1'b0, 32'h044, 1'b1, 1'b0};
        vt[6] = '{32'h050, 32'h0,   1'b1, 32'h050, 1'b0, 1'b0};
`endif

        // Reset asserted while rdy_in is low: reset must still take effect.
        do_reset();
        check("reset need_inst", ifc.need_inst, 1'b1);
        check("reset PC", ifc.PC, 32'h0);
        check("reset inst_ready_out", ifc.inst_ready_out, 1'b0);
        check("reset inst_addr", ifc.inst_addr, 32'h0);
        check("reset inst_out", ifc.inst_out, 32'h0);
        check("reset pred_taken", ifc.inst_pred_taken, 1'b0);

        // Decode table: redirect to pc, offer one word, inspect fetch decision.
        ifc.dc_stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.rob_clear     = 1'b1;
            ifc.rob_new_pc    = vt[i].pc;
            ifc.inst_ready_in = 1'b0;
            ifc.inst_in       = 32'd0;
            @(posedge clk_in);
            #1;
            ifc.rob_clear     = 1'b0;
            ifc.inst_ready_in = 1'b1;
            ifc.inst_in       = vt[i].inst;
            @(posedge clk_in);
            #1;
            ifc.inst_ready_in = 1'b0;
            ifc.inst_in       = 32'd0;
            check($sformatf("vec%0d need_inst", i), ifc.need_inst, vt[i].need);
            check($sformatf("vec%0d PC", i), ifc.PC, vt[i].npc);
            check($sformatf("vec%0d inst_ready_out", i), ifc.inst_ready_out, vt[i].valid);
            if (vt[i].valid) begin
                check($sformatf("vec%0d inst_addr", i), ifc.inst_addr, vt[i].pc);
                check($sformatf("vec%0d inst_out", i), ifc.inst_out, vt[i].inst);
                check($sformatf("vec%0d pred_taken", i), ifc.inst_pred_taken, vt[i].pred);
            end
        end

        // Sequential stream of six words, no decoder stall.
        do_reset();
        icache_en   = 1'b1;
        fetch_limit = 32'h18;
        repeat (20) step();
        check("seq delivered count", dlv.size(), 32'd6);
        for (int i = 0; i < 6; i++) check_dlv($sformatf("seq addr%0d", i), i, 32'(4 * i));
        if (dlv.size() == 6) check("seq back-to-back span", dlv_cyc[5] - dlv_cyc[0], 32'd5);

        // Backpressure: queue fills to DEPTH, then drains in order.
        do_reset();
        icache_en    = 1'b1;
        ifc.dc_stall = 1'b1;
        repeat (10) step();
        check("bp need_inst when full", ifc.need_inst, 1'b0);
        check("bp PC when full", ifc.PC, 32'h10);
        check("bp head when full", ifc.inst_addr, 32'h0);
        ifc.dc_stall = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 5; i++) check_dlv($sformatf("bp drain%0d", i), i, 32'(4 * i));

        // Control flow at 0x8; decoder redirects to 0x40 while consuming it.
        do_reset();
        icache_en  = 1'b1;
        sp_addr    = 32'h8;
        sp_inst    = BEQ_P8;
        redir_en   = 1'b1;
        redir_addr = 32'h8;
        redir_tgt  = 32'h40;
        repeat (20) step();
        check_dlv("halt addr0", 0, 32'h0);
        check_dlv("halt addr1", 1, 32'h4);
        check_dlv("halt addr2", 2, 32'h8);
        check_dlv("halt redirect addr", 3, 32'h40);

        // ROB flush with three queued and a same-cycle icache response.
        do_reset();
        icache_en    = 1'b1;
        ifc.dc_stall = 1'b1;
        repeat (3) step();
        ifc.rob_clear  = 1'b1;
        ifc.rob_new_pc = 32'h200;
        step();
        ifc.rob_clear = 1'b0;
        check("rob flush ready_out", ifc.inst_ready_out, 1'b0);
        check("rob flush PC", ifc.PC, 32'h200);
        ifc.rob_clear  = 1'b1;
        ifc.rob_new_pc = 32'h300;
        ifc.dc_clear   = 1'b1;
        ifc.dc_new_pc  = 32'h400;
        step();
        ifc.rob_clear = 1'b0;
        ifc.dc_clear  = 1'b0;
        check("rob+dc PC", ifc.PC, 32'h300);
        check("rob+dc ready_out", ifc.inst_ready_out, 1'b0);
        ifc.dc_stall = 1'b0;
        repeat (4) step();
        check_dlv("rob resume addr", 0, 32'h300);

`ifdef IFQ_STATIC_PREDICT_EN
        // Backward JAL at 0x20 is followed straight to 0x18.
        do_reset();
        icache_en = 1'b1;
        sp_addr   = 32'h20;
        sp_inst   = JAL_M8;
        repeat (16) step();
        check_dlv("jal addr", 8, 32'h20);
        check_dlv("jal target addr", 9, 32'h18);
        if (dlv_pred.size() > 8) check("jal pred_taken", dlv_pred[8], 1'b1);
`endif

        // rdy_in low for five cycles with every other input toggling.
        do_reset();
        icache_en = 1'b1;
        repeat (3) step();
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.dc_stall   = i[0];
            ifc.rob_clear  = i[1];
            ifc.rob_new_pc = 32'h500;
            ifc.dc_clear   = ~i[0];
            ifc.dc_new_pc  = 32'h600;
            icache_en      = i[0];
            step();
            check("frozen PC", ifc.PC, 32'hC);
            check("frozen head", ifc.inst_addr, 32'h8);
        end
        rdy_in        = 1'b1;
        ifc.rob_clear = 1'b0;
        ifc.dc_clear  = 1'b0;
        ifc.dc_stall  = 1'b0;
        icache_en     = 1'b1;
        repeat (6) step();
        check_dlv("thaw addr2", 2, 32'h8);
        check_dlv("thaw addr3", 3, 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
